// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// special instruction encodings and default widths.
package instr_fetch_pkg;

  localparam int DEF_PC_W = 10;
  localparam int DEF_IW   = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_LI_IMM = 2'd2,
    ST_HALT   = 2'd3
  } fetch_state_e;

  // HALT is the all-ones word; an li prefix has every bit above [1:0] clear.
  localparam logic [DEF_IW-1:0] HALT_WORD      = 9'h1FF;
  localparam logic [DEF_IW-1:0] LI_PREFIX_MASK = 9'h1FC;

endpackage

// File: rtl/instr_fetch_branch_lut.sv
// Constant branch target table, read combinationally by the low three bits
// of a beq instruction word.
module branch_lut #(
  parameter int PC_W = 10
) (
  input  logic [2:0]      idx_i,
  output logic [PC_W-1:0] target_o
);

  // Fixed target table lookup
  always_comb begin
    target_o = '0;
    case (idx_i)
      3'd0:    target_o = PC_W'(30);
      3'd1:    target_o = PC_W'(40);
      3'd2:    target_o = PC_W'(50);
      3'd3:    target_o = PC_W'(20);
      3'd4:    target_o = PC_W'(100);
      3'd5:    target_o = PC_W'(200);
      3'd6:    target_o = PC_W'(500);
      3'd7:    target_o = PC_W'(1000);
      default: target_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks a combinational ROM one word per cycle,
// follows taken branches without a bubble and tags li immediates.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int IW   = DEF_IW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_req,
  input  logic            branch_taken,
  input  logic [IW-1:0]   rom_data,
  output logic [PC_W-1:0] rom_addr,
  output logic [IW-1:0]   instr_o,
  output logic            instr_valid,
  output logic            imm_valid,
  output logic            done
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_target_s;
  logic [PC_W-1:0] pc_inc_s;
  logic            is_halt_s;
  logic            is_li_s;

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .idx_i    (rom_data[2:0]),
    .target_o (br_target_s)
  );

  assign pc_inc_s  = pc_q + PC_W'(1);
  assign is_halt_s = (rom_data == IW'(HALT_WORD));
  assign is_li_s   = ((rom_data & IW'(LI_PREFIX_MASK)) == '0);

  // Next-state and next-PC selection; stall freezes everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (stall) begin
      state_d = state_q;
      pc_d    = pc_q;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_d = ST_FETCH;
            pc_d    = '0;
          end else begin
            state_d = state_q;
            pc_d    = pc_q;
          end
        end
        ST_FETCH: begin
          if (is_halt_s) begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end else if (branch_req) begin
            state_d = ST_FETCH;
            pc_d    = branch_taken ? br_target_s : pc_inc_s;
          end else if (is_li_s) begin
            state_d = ST_LI_IMM;
            pc_d    = pc_inc_s;
          end else begin
            state_d = ST_FETCH;
            pc_d    = pc_inc_s;
          end
        end
        ST_LI_IMM: begin
          state_d = ST_FETCH;
          pc_d    = pc_inc_s;
        end
        default: begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end
      endcase
    end
  end

  // State and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs decode straight from state so reset clears them at once
  assign rom_addr    = pc_q;
  assign instr_o     = ((state_q == ST_FETCH) || (state_q == ST_LI_IMM)) ? rom_data : '0;
  assign instr_valid = (state_q == ST_FETCH);
  assign imm_valid   = (state_q == ST_LI_IMM);
  assign done        = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed program scenarios followed by
// randomized ROM contents and control inputs against a behavioural model.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch_req, branch_taken;
  logic [8:0] rom_data;
  logic [9:0] rom_addr;
  logic [8:0] instr_o;
  logic       instr_valid, imm_valid, done;

  logic [8:0] rom [0:1023];
  int lut_m [8] = '{30, 40, 50, 20, 100, 200, 500, 1000};

  // model: mode 0 idle, 1 executing, 2 immediate operand, 3 halted
  int m_mode;
  int m_pc;
  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_req   (branch_req),
    .branch_taken (branch_taken),
    .rom_data     (rom_data),
    .rom_addr     (rom_addr),
    .instr_o      (instr_o),
    .instr_valid  (instr_valid),
    .imm_valid    (imm_valid),
    .done         (done)
  );

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input bit s, input bit sl, input bit b, input bit t);
    int w;
    w = int'(rom[m_pc]);
    if (sl) return;
    case (m_mode)
      0, 3: if (s) begin m_mode = 1; m_pc = 0; end
      1: begin
        if (w == 511) m_mode = 3;
        else if (b) m_pc = t ? lut_m[w % 8] : (m_pc + 1) % 1024;
        else begin
          if (w < 4) m_mode = 2;
          m_pc = (m_pc + 1) % 1024;
        end
      end
      default: begin m_mode = 1; m_pc = (m_pc + 1) % 1024; end
    endcase
  endtask

  task automatic check_outputs();
    int exp_instr;
    exp_instr = (m_mode == 1 || m_mode == 2) ? int'(rom[m_pc]) : 0;
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("instr_o", 32'(instr_o), 32'(exp_instr));
    chk("instr_valid", 32'(instr_valid), 32'(m_mode == 1));
    chk("imm_valid", 32'(imm_valid), 32'(m_mode == 2));
    chk("done", 32'(done), 32'(m_mode == 3));
  endtask

  task automatic cycle(input bit s, input bit sl, input bit b, input bit t);
    start = s; stall = sl; branch_req = b; branch_taken = t;
    @(posedge clk);
    model_step(s, sl, b, t);
    @(negedge clk);
    check_outputs();
  endtask

  // Called just after a falling edge: pulses reset between clock edges
  task automatic async_reset();
    #2 reset = 1'b1;
    m_mode = 0;
    m_pc   = 0;
    #1;
    check_outputs();
    chk("rst_addr_lit", 32'(rom_addr), 32'd0);
    chk("rst_valid_lit", 32'(instr_valid | imm_valid | done), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; branch_req = 1'b0; branch_taken = 1'b0;
    m_mode = 0; m_pc = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h040 | 9'(i % 64);
    rom[3] = 9'h1FF;

    // three adds then HALT
    @(negedge clk);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("p0_valid_lit", 32'(instr_valid), 32'd1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("p3_addr_lit", 32'(rom_addr), 32'd3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_done_lit", 32'(done), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_pc_lit", 32'(rom_addr), 32'd3);

    // restart from HALT, then start ignored while fetching
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_pc_lit", 32'(rom_addr), 32'd0);
    chk("restart_done_lit", 32'(done), 32'd0);
    rom[3] = 9'h040; rom[4] = 9'h002; rom[5] = 9'h05A; rom[7] = 9'h03B;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_in_fetch_lit", 32'(rom_addr), 32'd1);

    // li at PC 4, immediate at PC 5, branch taken at PC 7
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("li_valid_lit", 32'(instr_valid), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("imm_valid_lit", 32'(imm_valid), 32'd1);
    chk("imm_word_lit", 32'(instr_o), 32'h05A);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_imm_lit", 32'(instr_valid), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("br_taken_lit", 32'(rom_addr), 32'd20);

    // rerun: stall in LI_IMM, branch not taken, stall at PC 9
    @(negedge clk);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_imm_lit", 32'(imm_valid), 32'd1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("br_not_taken_lit", 32'(rom_addr), 32'd8);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("stall_pc_lit", 32'(rom_addr), 32'd9);
    chk("stall_word_lit", 32'(instr_o), 32'h049);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_release_lit", 32'(rom_addr), 32'd10);

    // jump to 1000 and wrap past 1023
    rom[10] = 9'h03F;
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("br_1000_lit", 32'(rom_addr), 32'd1000);
    repeat (23) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pc_1023_lit", 32'(rom_addr), 32'd1023);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_lit", 32'(rom_addr), 32'd0);

    // reset mid-FETCH at PC 15, wait in IDLE, then start
    repeat (15) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pc15_lit", 32'(rom_addr), 32'd15);
    async_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_wait_lit", 32'(instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_start_lit", 32'(instr_valid), 32'd1);

    // randomized ROM and controls
    for (int i = 0; i < 1024; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) rom[i] = 9'h1FF;
      else if (r < 14) rom[i] = 9'($urandom_range(0, 3));
      else rom[i] = 9'($urandom_range(4, 510));
    end
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      cycle($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 20, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
